// File: rtl/alu_secuencial_if.sv
// Command/result bus for alu_secuencial.
// master: drives in_valid, A, B, s, out_ready; observes in_ready and the result/flags.
// slave:  the ALU side, mirror image of master.
interface alu_secuencial_if #(
    parameter int N = 4
);
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] A;
    logic [N-1:0] B;
    logic [2:0]   s;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] out;
    logic         cout;
    logic         zero;
    logic         neg;
    logic         ovf;
    logic         busy;

    modport master (
        output in_valid, A, B, s, out_ready,
        input  in_ready, out_valid, out, cout, zero, neg, ovf, busy
    );

    modport slave (
        input  in_valid, A, B, s, out_ready,
        output in_ready, out_valid, out, cout, zero, neg, ovf, busy
    );
endinterface

// File: rtl/alu_secuencial.sv
// Sequential ALU with valid/ready command and result handshakes.
// Add/sub/AND/XOR finish at the acceptance edge; shifts and rotates step one bit per cycle.
// Ports:
//   clk  - rising-edge clock
//   rst  - asynchronous active-high reset
//   bus  - alu_secuencial_if.slave: in_valid/in_ready/A/B/s command side,
//          out_valid/out_ready/out/cout/zero/neg/ovf result side, busy status
module alu_secuencial #(
    parameter int N = 4
) (
    input logic             clk,
    input logic             rst,
    alu_secuencial_if.slave bus
);
    localparam int CW = $clog2(N + 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_ASR = 3'b010;
    localparam logic [2:0] OP_SHL = 3'b011;
    localparam logic [2:0] OP_ROL = 3'b100;
    localparam logic [2:0] OP_ROR = 3'b101;
    localparam logic [2:0] OP_AND = 3'b110;
    localparam logic [2:0] OP_XOR = 3'b111;

    // The value N held in N+1 bits, for clamping and modulo of the shift amount.
    localparam logic [N:0] N_EXT = (N + 1)'(N);

    logic [1:0]    state_q, state_d;
    logic [N-1:0]  out_q, out_d;
    logic          cout_q, cout_d;
    logic          zero_q, zero_d;
    logic          neg_q, neg_d;
    logic          ovf_q, ovf_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    op_q, op_d;

    logic          accept;
    logic          upd;
    logic [N:0]    b_ext;
    logic [N:0]    sum;
    logic [N:0]    diff;
    logic [N:0]    rot_mod;
    logic [CW-1:0] cnt_load;

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.busy      = (state_q != IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.out       = out_q;
    assign bus.cout      = cout_q;
    assign bus.zero      = zero_q;
    assign bus.neg       = neg_q;
    assign bus.ovf       = ovf_q;

    assign accept = bus.in_valid && (state_q == IDLE);

    always_comb begin
        b_ext   = {1'b0, bus.B};
        sum     = {1'b0, bus.A} + b_ext;
        diff    = {1'b0, bus.A} - b_ext;
        rot_mod = b_ext % N_EXT;
        if (bus.s == OP_ROL || bus.s == OP_ROR) begin
            cnt_load = rot_mod[CW-1:0];
        end else if (b_ext >= N_EXT) begin
            // Shifting by N already yields the saturated result.
            cnt_load = N_EXT[CW-1:0];
        end else begin
            cnt_load = b_ext[CW-1:0];
        end
    end

    always_comb begin
        state_d = state_q;
        out_d   = out_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        upd     = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    op_d    = bus.s;
                    cout_d  = 1'b0;
                    ovf_d   = 1'b0;
                    upd     = 1'b1;
                    state_d = DONE;
                    case (bus.s)
                        OP_ADD: begin
                            out_d  = sum[N-1:0];
                            cout_d = sum[N];
                            ovf_d  = (bus.A[N-1] == bus.B[N-1]) && (sum[N-1] != bus.A[N-1]);
                        end
                        OP_SUB: begin
                            out_d  = diff[N-1:0];
                            cout_d = ~diff[N]; // high when no borrow
                            ovf_d  = (bus.A[N-1] != bus.B[N-1]) && (diff[N-1] != bus.A[N-1]);
                        end
                        OP_AND: out_d = bus.A & bus.B;
                        OP_XOR: out_d = bus.A ^ bus.B;
                        default: begin
                            out_d = bus.A;
                            cnt_d = cnt_load;
                            if (cnt_load != '0) begin
                                state_d = SHIFT;
                            end
                        end
                    endcase
                end
            end
            SHIFT: begin
                upd   = 1'b1;
                cnt_d = cnt_q - 1'b1;
                case (op_q)
                    OP_ASR: begin
                        out_d  = {out_q[N-1], out_q[N-1:1]};
                        cout_d = out_q[0];
                    end
                    OP_SHL: begin
                        out_d  = {out_q[N-2:0], 1'b0};
                        cout_d = out_q[N-1];
                    end
                    OP_ROL: begin
                        out_d  = {out_q[N-2:0], out_q[N-1]};
                        cout_d = out_q[N-1];
                    end
                    default: begin
                        out_d  = {out_q[0], out_q[N-1:1]};
                        cout_d = out_q[0];
                    end
                endcase
                if (cnt_q == CW'(1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Flags only move with out, so they stay 0 after reset until a result is written.
        zero_d = upd ? (out_d == '0) : zero_q;
        neg_d  = upd ? out_d[N-1] : neg_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            out_q   <= '0;
            cout_q  <= 1'b0;
            zero_q  <= 1'b0;
            neg_q   <= 1'b0;
            ovf_q   <= 1'b0;
            cnt_q   <= '0;
            op_q    <= '0;
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
            cout_q  <= cout_d;
            zero_q  <= zero_d;
            neg_q   <= neg_d;
            ovf_q   <= ovf_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
        end
    end
endmodule

// File: tb/tb_alu_secuencial.sv
// Self-checking bench for alu_secuencial (N=4): vector table with scoreboard queue,
// plus hand-written backpressure and mid-shift reset sequences.
module tb_alu_secuencial;
    localparam int N = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;

    alu_secuencial_if #(.N(N)) bus ();

    alu_secuencial #(.N(N)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] s;
        logic [3:0] a;
        logic [3:0] b;
        logic [3:0] out;
        logic       cout;
        logic       zero;
        logic       neg;
        logic       ovf;
        int         lat;
    } vec_t;

    typedef struct {
        logic [3:0] out;
        logic       cout;
        logic       zero;
        logic       neg;
        logic       ovf;
        int         lat;
    } exp_t;

    exp_t sb[$];
    vec_t vt[18];
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic run_op(input string tag, input logic [2:0] s, input logic [3:0] a,
                          input logic [3:0] b, input exp_t e);
        int   lat;
        int   k;
        exp_t got;
        @(negedge clk);
        k = 0;
        while (!bus.in_ready && k < 20) begin
            @(negedge clk);
            k++;
        end
        check({tag, " in_ready"}, 32'(bus.in_ready), 32'd1);
        if (!bus.in_ready) return;
        bus.in_valid = 1'b1;
        bus.s        = s;
        bus.A        = a;
        bus.B        = b;
        sb.push_back(e);
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        lat = 1;
        @(negedge clk);
        while (!bus.out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        if (!bus.out_valid) begin
            check({tag, " out_valid timeout"}, 32'd0, 32'd1);
            void'(sb.pop_front());
            return;
        end
        got = sb.pop_front();
        check({tag, " out"},     32'(bus.out),  32'(got.out));
        check({tag, " cout"},    32'(bus.cout), 32'(got.cout));
        check({tag, " zero"},    32'(bus.zero), 32'(got.zero));
        check({tag, " neg"},     32'(bus.neg),  32'(got.neg));
        check({tag, " ovf"},     32'(bus.ovf),  32'(got.ovf));
        check({tag, " latency"}, 32'(lat),      32'(got.lat));
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1 bus.out_ready = 1'b0;
        @(negedge clk);
        check({tag, " in_ready after consume"}, 32'(bus.in_ready), 32'd1);
        check({tag, " out_valid after consume"}, 32'(bus.out_valid), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        bit   seen_valid;

        //        s       A        B        out      cout  zero  neg   ovf   lat
        vt[0]  = '{3'b000, 4'b0111, 4'b0001, 4'b1000, 1'b0, 1'b0, 1'b1, 1'b1, 1};
        vt[1]  = '{3'b001, 4'b0011, 4'b0101, 4'b1110, 1'b0, 1'b0, 1'b1, 1'b0, 1};
        vt[2]  = '{3'b001, 4'b0101, 4'b0101, 4'b0000, 1'b1, 1'b1, 1'b0, 1'b0, 1};
        vt[3]  = '{3'b010, 4'b1010, 4'b0010, 4'b1110, 1'b1, 1'b0, 1'b1, 1'b0, 3};
        vt[4]  = '{3'b010, 4'b1010, 4'b1001, 4'b1111, 1'b1, 1'b0, 1'b1, 1'b0, 5};
        vt[5]  = '{3'b100, 4'b1001, 4'b0101, 4'b0011, 1'b1, 1'b0, 1'b0, 1'b0, 2};
        vt[6]  = '{3'b101, 4'b0110, 4'b0100, 4'b0110, 1'b0, 1'b0, 1'b0, 1'b0, 1};
        vt[7]  = '{3'b000, 4'b1111, 4'b0001, 4'b0000, 1'b1, 1'b1, 1'b0, 1'b0, 1};
        vt[8]  = '{3'b000, 4'b1000, 4'b1000, 4'b0000, 1'b1, 1'b1, 1'b0, 1'b1, 1};
        vt[9]  = '{3'b001, 4'b1000, 4'b0001, 4'b0111, 1'b1, 1'b0, 1'b0, 1'b1, 1};
        vt[10] = '{3'b110, 4'b1100, 4'b1010, 4'b1000, 1'b0, 1'b0, 1'b1, 1'b0, 1};
        vt[11] = '{3'b111, 4'b1100, 4'b1100, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b0, 1};
        vt[12] = '{3'b011, 4'b0011, 4'b0001, 4'b0110, 1'b0, 1'b0, 1'b0, 1'b0, 2};
        vt[13] = '{3'b011, 4'b1011, 4'b0111, 4'b0000, 1'b1, 1'b1, 1'b0, 1'b0, 5};
        vt[14] = '{3'b101, 4'b0110, 4'b0111, 4'b1100, 1'b1, 1'b0, 1'b1, 1'b0, 4};
        vt[15] = '{3'b100, 4'b1000, 4'b0010, 4'b0010, 1'b0, 1'b0, 1'b0, 1'b0, 3};
        vt[16] = '{3'b010, 4'b0110, 4'b0100, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b0, 5};
        vt[17] = '{3'b011, 4'b0001, 4'b0000, 4'b0001, 1'b0, 1'b0, 1'b0, 1'b0, 1};

        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.A         = '0;
        bus.B         = '0;
        bus.s         = '0;

        // Reset state
        #2;
        check("reset out",       32'(bus.out),       32'd0);
        check("reset cout",      32'(bus.cout),      32'd0);
        check("reset zero",      32'(bus.zero),      32'd0);
        check("reset neg",       32'(bus.neg),       32'd0);
        check("reset ovf",       32'(bus.ovf),       32'd0);
        check("reset out_valid", 32'(bus.out_valid), 32'd0);
        check("reset busy",      32'(bus.busy),      32'd0);
        check("reset in_ready",  32'(bus.in_ready),  32'd1);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("idle zero stays 0", 32'(bus.zero), 32'd0);

        for (int i = 0; i < 18; i++) begin
            e.out  = vt[i].out;
            e.cout = vt[i].cout;
            e.zero = vt[i].zero;
            e.neg  = vt[i].neg;
            e.ovf  = vt[i].ovf;
            e.lat  = vt[i].lat;
            run_op($sformatf("vec%0d", i), vt[i].s, vt[i].a, vt[i].b, e);
        end

        // Backpressure: result must hold while out_ready is low; in_valid is ignored.
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.s        = 3'b000;
        bus.A        = 4'b0010;
        bus.B        = 4'b0011;
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        @(negedge clk);
        check("bp out_valid", 32'(bus.out_valid), 32'd1);
        for (int c = 0; c < 5; c++) begin
            bus.in_valid = 1'b1;
            bus.s        = 3'b000;
            bus.A        = 4'b1111;
            bus.B        = 4'b1111;
            check($sformatf("bp%0d out", c),       32'(bus.out),       32'd5);
            check($sformatf("bp%0d flags", c),
                  32'({bus.cout, bus.zero, bus.neg, bus.ovf}), 32'd0);
            check($sformatf("bp%0d in_ready", c),  32'(bus.in_ready),  32'd0);
            check($sformatf("bp%0d out_valid", c), 32'(bus.out_valid), 32'd1);
            check($sformatf("bp%0d busy", c),      32'(bus.busy),      32'd1);
            @(negedge clk);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1 bus.out_ready = 1'b0;
        @(negedge clk);
        check("bp in_ready after consume",  32'(bus.in_ready),  32'd1);
        check("bp out_valid after consume", 32'(bus.out_valid), 32'd0);
        check("bp busy after consume",      32'(bus.busy),      32'd0);

        // Async reset one step into a left shift by 3.
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.s        = 3'b011;
        bus.A        = 4'b0001;
        bus.B        = 4'b0011;
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        @(posedge clk);
        #1;
        check("mid-shift busy", 32'(bus.busy), 32'd1);
        #1 rst = 1'b1;
        #1;
        check("abort out",       32'(bus.out),       32'd0);
        check("abort flags",
              32'({bus.cout, bus.zero, bus.neg, bus.ovf}), 32'd0);
        check("abort out_valid", 32'(bus.out_valid), 32'd0);
        check("abort busy",      32'(bus.busy),      32'd0);
        check("abort in_ready",  32'(bus.in_ready),  32'd1);
        seen_valid = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (c == 1) rst = 1'b0;
            if (bus.out_valid) seen_valid = 1'b1;
        end
        check("abort no result emitted", 32'(seen_valid), 32'd0);

        e = '{out: 4'b0101, cout: 1'b0, zero: 1'b0, neg: 1'b0, ovf: 1'b0, lat: 1};
        run_op("post-reset add", 3'b000, 4'b0010, 4'b0011, e);

        check("scoreboard drained", 32'(sb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/alu_secuencial.md
Name: alu_secuencial

Overview:
- Parametrised sequential successor to the combinational arithmetic mux.
- Accepts one operation per valid/ready handshake and registers the result with status flags.
- Add, subtract and logic ops complete in 1 cycle.
- Shifts and rotates run iteratively, one bit position per cycle.
- Sits between the operand register file and the result writeback stage of the datapath.

Parameters:
- N, 4, operand/result width in bits; legal range N >= 2.
- CW, $clog2(N+1), shift-count register width; derived, not to be overridden.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous reset, active-high.
- in_valid  in  1  A, B, s are valid this cycle.
- in_ready  out  1  block can accept a command; high only in IDLE.
- A  in  N  operand A (shift/rotate source).
- B  in  N  operand B; shift/rotate amount for s=010..101.
- s  in  3  opcode: 000 add, 001 sub, 010 arith-right, 011 left, 100 rotate-left, 101 rotate-right, 110 AND, 111 XOR.
- out_valid  out  1  result and flags are valid.
- out_ready  in  1  consumer accepts the result.
- out  out  N  registered result.
- cout  out  1  carry flag.
- zero  out  1  out == 0.
- neg  out  1  out[N-1].
- ovf  out  1  signed overflow, add/sub only.
- busy  out  1  state != IDLE.

Behaviour:
- Reset (async, rst=1):
  - state=IDLE; out, cout, zero, neg, ovf, out_valid, busy all 0.
  - in_ready is 1 while rst is high.
  - Reset mid-operation aborts the operation with no result emitted.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - in_ready=1. A command is accepted on (in_valid & in_ready); A, B, s are captured.
  - Add/sub/logic: result computed and registered at the acceptance edge; next state DONE. out_valid is high the following cycle (latency 1).
  - Shift/rotate: work reg = A, cnt loaded; next state SHIFT. If cnt==0, go straight to DONE with out=A and cout=0.
- Shift count:
  - Arith-right/left: cnt = min(B, N), unsigned.
  - Rotates: cnt = B mod N.
- SHIFT:
  - Each cycle: one-bit step of the op; cnt decrements; cout = bit shifted/rotated out on that step.
  - When cnt reaches 1, the final step is performed and the next state is DONE.
  - Total latency = 1 + cnt cycles from acceptance to out_valid.
  - Arith-right fills with A[N-1]; left fills with 0.
  - Arith-right by >= N gives all sign bits; left by >= N gives 0.
- DONE:
  - out_valid=1; out and flags held stable.
  - On out_ready=1 the result is consumed and the next state is IDLE. in_ready rises the cycle after.
  - No back-to-back acceptance in the same cycle as result consumption.
- Arithmetic:
  - Add: {cout,out} = A+B, N+1 bits; ovf = (A[N-1]==B[N-1]) & (out[N-1]!=A[N-1]).
  - Sub: out = A-B modulo 2^N; cout = 1 when no borrow (A >= B unsigned); ovf = (A[N-1]!=B[N-1]) & (out[N-1]!=A[N-1]).
  - Logic ops: cout=0, ovf=0.
  - ovf=0 for all non-add/sub ops.
- Flag update:
  - zero and neg are updated whenever out is updated; both refer to the final result in DONE.
  - In SHIFT, out, cout, zero and neg all track the working register. They are only meaningful when out_valid=1.
- in_valid while busy is ignored: no capture and no error.
- out_ready while not in DONE is ignored.

Test Plan:
- N=4, add A=0111 B=0001 → 1 cycle later out_valid=1, out=1000, cout=0, ovf=1, neg=1, zero=0.
- N=4, sub A=0011 B=0101 → out=1110, cout=0, ovf=0, neg=1. Then sub A=0101 B=0101 → out=0000, cout=1, zero=1.
- N=4, arith-right A=1010 B=0010 → out_valid after 3 cycles, out=1110, cout=1. Repeat with B=1001 → cnt clamped to 4, out_valid after 5 cycles, out=1111.
- N=4, rotate-left A=1001 B=0101 → cnt=1, out=0011, cout=1, latency 2. Rotate-right A=0110 B=0100 → cnt=0, out=0110, cout=0, latency 1.
- Backpressure: hold out_ready=0 for 5 cycles in DONE → out and flags stable, in_ready=0, extra in_valid pulses ignored. Assert out_ready → IDLE next cycle, in_ready=1.
- Assert rst asynchronously mid-SHIFT (left A=0001 B=0011, after 1 step) → all outputs 0 immediately, out_valid never asserted. After release, a new add A=0010 B=0011 gives out=0101.
